ssp_tx_ctrl: RTL and testbench
==============================

# ssp_tx_ctrl

Transmit sequencer for the synchronous serial port. It pulls bytes from the TX FIFO using the `transmit_complete`/`tx_ready` handshake and serializes each byte MSB-first as a TI-style synchronous serial frame on `SSPTXD`, `SSPCLKOUT` and `SSPFSSOUT`. It sits between the TX FIFO and the serial pins, and is the only agent that advances the FIFO read side.

## Interface
- `CLK_DIV`, default 1: PCLK cycles per serial-clock half-period (H); legal range 1..255.
- `PCLK  in  1`: system clock; all state changes on its rising edge.
- `CLEAR_B  in  1`: asynchronous, active-low reset.
- `SSE  in  1`: port enable; level-sensitive.
- `tx_ready  in  1`: FIFO one-cycle pulse; `TxData` is valid in the same cycle.
- `TxData  in  8`: byte from FIFO.
- `transmit_complete  out  1`: one-cycle request to the FIFO for the next byte.
- `SSPTXD  out  1`: serial data.
- `SSPCLKOUT  out  1`: serial clock.
- `SSPFSSOUT  out  1`: frame sync pulse.
- `SSPOE  out  1`: output enable for `SSPTXD`.
- `SSPBSY  out  1`: a frame is in progress.
- `tx_count  out  8`: frames sent; wraps 255 -> 0.

## Operation
- All outputs are registered. Under reset, every output is 0, the state is IDLE, and the shift register and counters are 0.
- The FSM has five states: IDLE, REQ, WAIT, FRAME and SHIFT.
- **IDLE**: if `SSE`=1, go to REQ; otherwise stay in IDLE.
- **REQ**: drive `transmit_complete`=1 for exactly this one cycle, then go to WAIT.
- **WAIT**: sample `tx_ready`.
  - If it is 1: load the shift register from `TxData`, clear the bit and half-period counters, and go to FRAME.
  - If it is 0 (FIFO empty): go to IDLE. The request is retried from IDLE.
- **FRAME**: lasts one bit period (2H cycles).
  - `SSPFSSOUT`=1.
  - `SSPCLKOUT`=1 for the first H cycles, then 0 for the next H cycles.
  - `SSPTXD`=0 and `SSPOE`=0.
  - Then go to SHIFT.
- **SHIFT**: eight bit periods of 2H cycles each.
  - `SSPTXD` = shift register bit 7 for the whole bit period.
  - `SSPCLKOUT` is high for the first half and low for the second half. Data changes at the rising edge; the receiver samples at the falling edge.
  - `SSPOE`=1.
  - At the end of each bit period, shift left by one with 0 fill.
  - After the 8th bit period: increment `tx_count`, then go to REQ if `SSE`=1, else to IDLE.
- `SSPBSY`=1 in FRAME and SHIFT, 0 otherwise.
- Outside FRAME and SHIFT: `SSPCLKOUT`, `SSPFSSOUT`, `SSPTXD` and `SSPOE` are all 0.
- Deasserting `SSE` mid-frame does not truncate the frame. The current frame completes, then the FSM goes to IDLE.
- Asserting `CLEAR_B`=0 mid-frame aborts immediately. All outputs go to 0 asynchronously and the byte is lost.
- The half-period counter is 8 bits wide and counts 0..H-1. The bit counter is 3 bits wide and counts 0..7.

## Timing
- Successive `transmit_complete` pulses are always ≥2 PCLK cycles apart, because the FIFO advances its read pointer one cycle after `tx_ready`.
  - The empty-retry loop IDLE->REQ->WAIT gives a spacing of 3 cycles.
  - The data path gives a spacing of 2H+16H+2 cycles.
- Schedule, with the REQ cycle at t0:
  - `tx_ready` is sampled at t1.
  - FRAME runs t2..t2+2H-1.
  - SHIFT runs t2+2H..t2+18H-1.
  - The next REQ is at t2+18H.
- Frame period with a continuously non-empty FIFO is 18H+2 PCLK cycles.
- `tx_count` updates on the same edge that leaves SHIFT.
- `tx_ready` arriving in any state other than WAIT is ignored.

## Test plan
- **Reset values**: assert `CLEAR_B`=0 asynchronously, mid-SHIFT, with `CLK_DIV`=1.
  - All outputs must be 0 immediately.
  - After release, the first REQ must occur one cycle after `SSE` is seen high.
- **Single byte**: FIFO holds 0xA5, `CLK_DIV`=1.
  - `transmit_complete` pulses at t0; FRAME occupies t2..t3.
  - `SSPTXD` = 1,0,1,0,0,1,0,1 in the 2-cycle bit periods starting at t4.
  - `SSPOE` is high over t4..t19; `tx_count`=1 at t20.
- **Empty FIFO**: `SSE`=1 with `tx_ready` never asserted.
  - `transmit_complete` pulses every 3 cycles.
  - `SSPBSY`, `SSPCLKOUT` and `SSPFSSOUT` stay 0.
- **Back-to-back**: bytes 0x81 then 0x7E, `CLK_DIV`=2.
  - The second `transmit_complete` pulse comes 38 cycles after the first.
  - `SSPCLKOUT` half-periods are 2 cycles each.
  - Serial stream: 1,0,0,0,0,0,0,1 then 0,1,1,1,1,1,1,0; `tx_count`=2.
- **SSE dropped mid-frame**: deassert `SSE` during bit 3 of byte 0xC3.
  - All 8 bits must be sent.
  - The FSM then goes to IDLE with no further `transmit_complete`.
- **Counter wrap**: send 256 frames.
  - `tx_count` reads 255 after frame 255 and 0 after frame 256.

Source files
------------

// File: rtl/ssp_tx_ctrl.sv
// ssp_tx_ctrl: fetches bytes from the TX FIFO and sends each one MSB-first as a TI-style frame (FSS bit period + 8 data bit periods).
// Latency: REQ to FRAME is 2 PCLK, a frame is 18*CLK_DIV PCLK; one byte is requested per frame and an empty FIFO is retried via IDLE.
module ssp_tx_ctrl #(
    parameter int CLK_DIV = 1
) (
    input  logic       PCLK,
    input  logic       CLEAR_B,
    input  logic       SSE,
    input  logic       tx_ready,
    input  logic [7:0] TxData,
    output logic       transmit_complete,
    output logic       SSPTXD,
    output logic       SSPCLKOUT,
    output logic       SSPFSSOUT,
    output logic       SSPOE,
    output logic       SSPBSY,
    output logic [7:0] tx_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_FRAME = 3'd3;
    localparam logic [2:0] S_SHIFT = 3'd4;

    localparam logic [7:0] HCNT_MAX = 8'(CLK_DIV - 1);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] hcnt;
    logic [7:0] hcnt_nxt;
    logic       half;
    logic       half_nxt;
    logic [2:0] bit_cnt;
    logic [2:0] bit_nxt;
    logic [7:0] shreg;
    logic [7:0] shreg_nxt;
    logic [7:0] count_nxt;
    logic       half_end;
    logic       in_frame;
    logic       in_shift;

    assign half_end = (hcnt == HCNT_MAX);

    // half=0 is the SSPCLKOUT-high half of a bit period, half=1 the low half.
    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        half_nxt  = half;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        count_nxt = tx_count;
        case (state)
            S_IDLE: begin
                if (SSE) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (tx_ready) begin
                    shreg_nxt = TxData;
                    hcnt_nxt  = 8'd0;
                    half_nxt  = 1'b0;
                    bit_nxt   = 3'd0;
                    state_nxt = S_FRAME;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_FRAME: begin
                if (half_end) begin
                    hcnt_nxt = 8'd0;
                    half_nxt = ~half;
                    if (half) begin
                        state_nxt = S_SHIFT;
                    end
                end else begin
                    hcnt_nxt = hcnt + 8'd1;
                end
            end
            S_SHIFT: begin
                if (half_end) begin
                    hcnt_nxt = 8'd0;
                    half_nxt = ~half;
                    if (half) begin
                        shreg_nxt = {shreg[6:0], 1'b0};
                        if (bit_cnt == 3'd7) begin
                            bit_nxt   = 3'd0;
                            count_nxt = tx_count + 8'd1;
                            state_nxt = SSE ? S_REQ : S_IDLE;
                        end else begin
                            bit_nxt = bit_cnt + 3'd1;
                        end
                    end
                end else begin
                    hcnt_nxt = hcnt + 8'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign in_frame = (state_nxt == S_FRAME);
    assign in_shift = (state_nxt == S_SHIFT);

    // Pin outputs are decoded from next-state so they line up with the state register.
    always_ff @(posedge PCLK or negedge CLEAR_B) begin
        if (!CLEAR_B) begin
            state             <= S_IDLE;
            hcnt              <= 8'd0;
            half              <= 1'b0;
            bit_cnt           <= 3'd0;
            shreg             <= 8'd0;
            tx_count          <= 8'd0;
            transmit_complete <= 1'b0;
            SSPTXD            <= 1'b0;
            SSPCLKOUT         <= 1'b0;
            SSPFSSOUT         <= 1'b0;
            SSPOE             <= 1'b0;
            SSPBSY            <= 1'b0;
        end else begin
            state             <= state_nxt;
            hcnt              <= hcnt_nxt;
            half              <= half_nxt;
            bit_cnt           <= bit_nxt;
            shreg             <= shreg_nxt;
            tx_count          <= count_nxt;
            transmit_complete <= (state_nxt == S_REQ);
            SSPBSY            <= in_frame | in_shift;
            SSPFSSOUT         <= in_frame;
            SSPCLKOUT         <= (in_frame | in_shift) & ~half_nxt;
            SSPOE             <= in_shift;
            SSPTXD            <= in_shift & shreg_nxt[7];
        end
    end

endmodule

// File: tb/tb_ssp_tx_ctrl.sv
// Bench for ssp_tx_ctrl: two instances (CLK_DIV 1 and 2) sharing one FIFO model, selected by sel.
module tb_ssp_tx_ctrl;

    typedef struct packed {
        logic tc;
        logic bsy;
        logic fss;
        logic clk;
        logic oe;
        logic txd;
    } obs_t;

    typedef struct {
        logic sse;
        obs_t exp;
    } vec_t;

    localparam obs_t O_IDLE = 6'b000000;
    localparam obs_t O_REQ  = 6'b100000;

    logic       PCLK;
    logic       clear_b;
    logic       sse;
    logic       sel;
    logic       tx_ready;
    logic [7:0] txdata;

    logic       sse_a, sse_b, rdy_a, rdy_b;
    logic       tc_a, txd_a, clk_a, fss_a, oe_a, bsy_a;
    logic       tc_b, txd_b, clk_b, fss_b, oe_b, bsy_b;
    logic [7:0] cnt_a, cnt_b, count;
    obs_t       obs_a, obs_b, obs;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] q[$];
    logic [7:0] sent[$];
    logic [7:0] rx[$];
    bit         mon_en  = 0;
    bit         spur_en = 0;

    assign sse_a = sse & ~sel;
    assign sse_b = sse & sel;
    assign rdy_a = tx_ready & ~sel;
    assign rdy_b = tx_ready & sel;
    assign obs_a = {tc_a, bsy_a, fss_a, clk_a, oe_a, txd_a};
    assign obs_b = {tc_b, bsy_b, fss_b, clk_b, oe_b, txd_b};
    assign obs   = sel ? obs_b : obs_a;
    assign count = sel ? cnt_b : cnt_a;

    ssp_tx_ctrl #(.CLK_DIV(1)) u_h1 (
        .PCLK(PCLK), .CLEAR_B(clear_b), .SSE(sse_a), .tx_ready(rdy_a), .TxData(txdata),
        .transmit_complete(tc_a), .SSPTXD(txd_a), .SSPCLKOUT(clk_a), .SSPFSSOUT(fss_a),
        .SSPOE(oe_a), .SSPBSY(bsy_a), .tx_count(cnt_a)
    );

    ssp_tx_ctrl #(.CLK_DIV(2)) u_h2 (
        .PCLK(PCLK), .CLEAR_B(clear_b), .SSE(sse_b), .tx_ready(rdy_b), .TxData(txdata),
        .transmit_complete(tc_b), .SSPTXD(txd_b), .SSPCLKOUT(clk_b), .SSPFSSOUT(fss_b),
        .SSPOE(oe_b), .SSPBSY(bsy_b), .tx_count(cnt_b)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected pins k cycles after the REQ cycle of a frame carrying byte b at half-period h.
    function automatic obs_t exp_obs(input logic [7:0] b, input int h, input int k);
        obs_t e;
        int   s;
        e = '0;
        if (k == 0) begin
            e.tc = 1'b1;
        end else if (k >= 2 && k < 2 + 2 * h) begin
            e.fss = 1'b1;
            e.bsy = 1'b1;
            e.clk = ((k - 2) < h);
        end else if (k >= 2 + 2 * h && k < 2 + 18 * h) begin
            s     = k - 2 - 2 * h;
            e.bsy = 1'b1;
            e.oe  = 1'b1;
            e.clk = ((s % (2 * h)) < h);
            e.txd = b[7 - s / (2 * h)];
        end
        return e;
    endfunction

    task automatic wait_req(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge PCLK); #1;
            if (obs.tc) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL %s_req: got no transmit_complete within 100 cycles, expected one", name);
        end
    endtask

    // Called in the REQ cycle; returns in the cycle the next REQ is due.
    task automatic check_frame(input string name, input logic [7:0] b, input int h,
                               input logic [7:0] cnt_exp, input logic next_req, input int drop_k);
        int   bad;
        int   first_k;
        obs_t e, first_act, first_exp;
        bad = 0; first_k = -1; first_act = '0; first_exp = '0;
        for (int k = 1; k < 2 + 18 * h; k++) begin
            @(posedge PCLK); #1;
            e = exp_obs(b, h, k);
            if (obs !== e) begin
                if (bad == 0) begin
                    first_k = k; first_act = obs; first_exp = e;
                end
                bad++;
            end
            if (k == drop_k) sse = 1'b0;
        end
        n_checks++;
        if (bad == 0) n_pass++;
        else $display("FAIL %s_wave: %0d bad cycles, first at t0+%0d got %b expected %b (tc,bsy,fss,clk,oe,txd)",
                      name, bad, first_k, first_act, first_exp);
        @(posedge PCLK); #1;
        chk({name, "_count"}, 32'(count), 32'(cnt_exp));
        chk({name, "_next_req"}, 32'(obs.tc), 32'(next_req));
    endtask

    // FIFO: answers a request with tx_ready in the following cycle; may inject ignored pulses.
    initial begin
        bit req_seen;
        req_seen = 1'b0;
        tx_ready = 1'b0;
        txdata   = 8'd0;
        forever begin
            @(posedge PCLK); #1;
            tx_ready = 1'b0;
            if (req_seen && q.size() > 0) begin
                txdata   = q.pop_front();
                tx_ready = 1'b1;
                sent.push_back(txdata);
            end else if (spur_en && !req_seen && $urandom_range(0, 7) == 0) begin
                txdata   = 8'($urandom);
                tx_ready = 1'b1;
            end
            req_seen = obs.tc;
        end
    end

    // Receiver model: captures SSPTXD on each falling SSPCLKOUT while SSPOE is high.
    initial begin
        obs_t       prev;
        logic [7:0] sh;
        int         nb;
        int         gap;
        bit         seen;
        prev = '0; sh = 8'd0; nb = 0; gap = 0; seen = 1'b0;
        forever begin
            @(posedge PCLK); #1;
            if (!mon_en) begin
                nb = 0; seen = 1'b0;
            end else begin
                if (prev.clk && !obs.clk && prev.oe) begin
                    sh = {sh[6:0], prev.txd};
                    nb++;
                    if (nb == 8) begin
                        rx.push_back(sh);
                        nb = 0;
                    end
                end
                gap++;
                if (obs.tc) begin
                    if (seen) chk("tc_spacing", 32'(gap >= 2), 32'd1);
                    gap = 0; seen = 1'b1;
                end
            end
            prev = obs;
        end
    end

    initial begin
        vec_t       tbl[14];
        bit         ok;
        logic [7:0] cnt0;
        logic [7:0] wbytes[256];
        int         ntc;

        clear_b = 1'b0; sse = 1'b0; sel = 1'b0;
        tbl[0]  = '{1'b0, O_IDLE}; tbl[1]  = '{1'b1, O_REQ};  tbl[2]  = '{1'b1, O_IDLE};
        tbl[3]  = '{1'b1, O_IDLE}; tbl[4]  = '{1'b1, O_REQ};  tbl[5]  = '{1'b0, O_IDLE};
        tbl[6]  = '{1'b0, O_IDLE}; tbl[7]  = '{1'b0, O_IDLE}; tbl[8]  = '{1'b1, O_REQ};
        tbl[9]  = '{1'b1, O_IDLE}; tbl[10] = '{1'b1, O_IDLE}; tbl[11] = '{1'b1, O_REQ};
        tbl[12] = '{1'b0, O_IDLE}; tbl[13] = '{1'b0, O_IDLE};

        repeat (3) @(posedge PCLK); #1;
        chk("rst_pins_h1", 32'(obs_a), 32'd0);
        chk("rst_pins_h2", 32'(obs_b), 32'd0);
        chk("rst_count_h1", 32'(cnt_a), 32'd0);
        chk("rst_count_h2", 32'(cnt_b), 32'd0);
        @(negedge PCLK) clear_b = 1'b1;
        repeat (2) @(negedge PCLK);

        q.push_back(8'hA5); sse = 1'b1;
        wait_req("single", ok);
        if (ok) check_frame("single", 8'hA5, 1, 8'd1, 1'b1, -1);
        sse = 1'b0;
        repeat (4) @(negedge PCLK);

        q.delete(); q.push_back(8'h3C); sse = 1'b1;
        wait_req("abort", ok);
        if (ok) begin
            repeat (8) @(posedge PCLK);
            #1 chk("abort_pre_oe", 32'(obs_a.oe), 32'd1);
            #2 clear_b = 1'b0;
            #1;
            chk("abort_pins", 32'(obs_a), 32'd0);
            chk("abort_count", 32'(cnt_a), 32'd0);
        end
        clear_b = 1'b0; sse = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK) clear_b = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(negedge PCLK); sse = tbl[i].sse;
            @(posedge PCLK); #1;
            chk($sformatf("idle_vec%0d", i), 32'(obs), 32'(tbl[i].exp));
        end

        @(negedge PCLK);
        sel = 1'b1; q.delete(); q.push_back(8'h81); q.push_back(8'h7E); sse = 1'b1;
        wait_req("b2b", ok);
        if (ok) begin
            check_frame("b2b_81", 8'h81, 2, 8'd1, 1'b1, -1);
            check_frame("b2b_7e", 8'h7E, 2, 8'd2, 1'b1, -1);
        end
        sse = 1'b0;
        repeat (5) @(negedge PCLK);
        sel = 1'b0;

        q.delete(); q.push_back(8'hC3); sse = 1'b1;
        wait_req("drop", ok);
        if (ok) check_frame("drop", 8'hC3, 1, 8'd1, 1'b0, 10);
        sse = 1'b0;
        ntc = 0;
        repeat (12) begin
            @(posedge PCLK); #1;
            if (obs.tc) ntc++;
        end
        chk("drop_no_req", 32'(ntc), 32'd0);

        @(negedge PCLK);
        q.delete(); sent.delete(); rx.delete();
        cnt0 = cnt_a; mon_en = 1'b1; spur_en = 1'b1;
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 3) != 0) q.push_back(8'($urandom));
            sse = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(1, 30)) @(negedge PCLK);
        end
        sse = 1'b0; spur_en = 1'b0;
        repeat (30) @(negedge PCLK);
        mon_en = 1'b0;
        q.delete();
        chk("rnd_traffic", 32'(sent.size() >= 5), 32'd1);
        chk("rnd_nbytes", 32'(rx.size()), 32'(sent.size()));
        for (int i = 0; i < rx.size() && i < sent.size(); i++)
            chk($sformatf("rnd_byte%0d", i), 32'(rx[i]), 32'(sent[i]));
        chk("rnd_count", 32'(cnt_a), 32'(8'(cnt0 + 8'(sent.size()))));

        @(negedge PCLK) clear_b = 1'b0;
        @(negedge PCLK) clear_b = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wbytes[i] = 8'($urandom);
            q.push_back(wbytes[i]);
        end
        sse = 1'b1;
        wait_req("wrap", ok);
        if (ok) begin
            for (int i = 0; i < 256; i++)
                check_frame($sformatf("wrap%0d", i), wbytes[i], 1, 8'(i + 1), 1'b1, -1);
        end
        sse = 1'b0;
        repeat (5) @(negedge PCLK);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
